// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and default framing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module      : uart_sync
// Description : Reset-to-one flop chain bringing the async RXD line into i_clk.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : Oversampling UART receiver with valid/ready output, framing,
//               overrun and (with UART_RX_PARITY_EN defined) even-parity check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tick,
    input  logic                 i_rxd,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_parity_err
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [PW-1:0] c_phase_last = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] c_phase_mid  = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] c_bit_last   = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_t c_after_data = PARITY;
`else
    localparam uart_state_t c_after_data = STOP;
`endif

    uart_state_t          r_state;
    logic [PW-1:0]        r_phase;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 w_rxd;
    logic                 w_phase_end;
    logic                 w_par_bad;
    logic                 w_complete;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_rxd),
        .o_q   (w_rxd)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    assign w_par_bad    = r_par_bad;
    assign o_parity_err = r_parity_err;
`else
    assign w_par_bad    = 1'b0;
    assign o_parity_err = 1'b0;
`endif

    assign w_phase_end = (r_phase == c_phase_last);
    // A good stop bit delivers the word unless parity already condemned it.
    assign w_complete  = i_tick && (r_state == STOP) && w_phase_end && w_rxd && !w_par_bad;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (w_complete) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (i_tick) begin
                case (r_state)
                    IDLE: begin
                        if (!w_rxd) begin
                            r_state <= START;
                            r_phase <= '0;
                        end
                    end
                    START: begin
                        if (r_phase == c_phase_mid) begin
                            if (w_rxd) begin
                                r_state <= IDLE;
                            end else begin
                                r_state   <= DATA;
                                r_phase   <= '0;
                                r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_par_bad <= 1'b0;
`endif
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    DATA: begin
                        if (w_phase_end) begin
                            r_shift   <= {w_rxd, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_phase   <= '0;
                            if (r_bit_cnt == c_bit_last) begin
                                r_state <= c_after_data;
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (w_phase_end) begin
                            r_par_bad <= ^{w_rxd, r_shift};
                            r_phase   <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (w_phase_end) begin
                            r_phase <= '0;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= r_par_bad;
`endif
                            if (w_rxd) begin
                                r_state <= IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_phase <= r_phase + 1'b1;
                        end
                    end
                    BREAK: begin
                        // Held-low line must go idle before a new start is accepted.
                        if (w_rxd) begin
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_busy      = (r_state != IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed scoreboard bench for uart_rx (8 data bits, x16 ticks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err, overrun, parity_err;

    int tests = 0;
    int failed = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int perr_cnt = 0;
    int v0, f0, o0, p0;
    logic [7:0] sb_q[$];

    uart_rx #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tick       (tick),
        .i_rxd        (rxd),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_busy       (busy),
        .o_frame_err  (frame_err),
        .o_overrun    (overrun),
        .o_parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Divide-by-4 tick, changed on the falling edge so it is stable at posedge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_word", {24'h0, data}, 32'hFFFF_FFFF);
                end else begin
                    check("word", {24'h0, data}, {24'h0, sb_q.pop_front()});
                end
            end
            if (frame_err)  ferr_cnt++;
            if (overrun)    ovr_cnt++;
            if (parity_err) perr_cnt++;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ bad_par);
`else
        if (bad_par) $display("[TB] parity override ignored without parity build");
`endif
        send_bit(stop_bit);
        rxd = 1'b1;
    endtask

    task automatic snap();
        v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_errs", {29'h0, frame_err, overrun, parity_err}, 32'h0);
        rst = 1'b0;
        wait_ticks(8);

        // Clean 0xA5 frame.
        snap();
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_ticks(4);
        check("a5_valid_cnt", valid_cnt - v0, 1);
        check("a5_errs", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 0);
        check("a5_busy", {31'h0, busy}, 32'h0);

        // Short low glitch is rejected as a false start.
        snap();
        rxd = 1'b0;
        wait_ticks(5);
        check("glitch_busy_hi", {31'h0, busy}, 32'h1);
        rxd = 1'b1;
        wait_ticks(20);
        check("glitch_busy_lo", {31'h0, busy}, 32'h0);
        check("glitch_no_word", valid_cnt - v0, 0);
        check("glitch_errs", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        // Bad stop bit, line held low, then recovery with 0x81.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        wait_ticks(40);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_no_word", valid_cnt - v0, 0);
        check("ferr_busy_hold", {31'h0, busy}, 32'h1);
        rxd = 1'b1;
        wait_ticks(4);
        check("ferr_busy_release", {31'h0, busy}, 32'h0);
        sb_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(4);
        check("recover_word", valid_cnt - v0, 1);
        check("recover_ferr", ferr_cnt - f0, 1);

        // Reset during data bit 4, then a clean 0x5A.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rxd = 1'b0;
        wait_ticks(8);
        check("mid_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_outs", {data, valid, busy, frame_err, overrun, parity_err}, 32'h0);
        rst = 1'b0;
        wait_ticks(20);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_ticks(4);
        check("after_rst_word", valid_cnt - v0, 1);

        // Back-to-back frames with the consumer stalled.
        snap();
        ready = 1'b0;
        sb_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_ticks(4);
        check("ovr_cnt", ovr_cnt - o0, 1);
        check("ovr_valid", {31'h0, valid}, 32'h1);
        check("ovr_data_held", {24'h0, data}, 32'h0);
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("ovr_drain_valid", {31'h0, valid}, 32'h0);
        check("ovr_drain_cnt", valid_cnt - v0, 1);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1.
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_ticks(4);
        check("par_err_cnt", perr_cnt - p0, 1);
        check("par_err_no_word", valid_cnt - v0, 0);
        sb_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_ticks(4);
        check("par_ok_word", valid_cnt - v0, 1);
        check("par_ok_no_err", perr_cnt - p0, 1);
`else
        check("parity_tied", {31'h0, parity_err}, 32'h0);
        check("parity_never", perr_cnt, 0);
`endif

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
